// File: rtl/axi_sys_master.sv
// axi_sys_master: single-beat AXI3 initiator driven by a simple addr/wdata/sel/wen/ren request bus.
// Optional watchdog with DRAIN recovery is enabled by defining AXI_SYS_MASTER_TIMEOUT_EN.
module axi_sys_master #(
    parameter int AXI_DW      = 32,
    parameter int AXI_AW      = 32,
    parameter int AXI_IW      = 12,
    parameter int AXI_ID      = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              axi_clk_i,
    input  logic              axi_rst_i,
    input  logic [AXI_AW-1:0] req_addr_i,
    input  logic [AXI_DW-1:0] req_wdata_i,
    input  logic [3:0]        req_sel_i,
    input  logic              req_wen_i,
    input  logic              req_ren_i,
    output logic [AXI_DW-1:0] req_rdata_o,
    output logic              req_ack_o,
    output logic              req_err_o,
    output logic              req_busy_o,
    output logic [AXI_IW-1:0] axi_awid_o,
    output logic [AXI_AW-1:0] axi_awaddr_o,
    output logic [3:0]        axi_awlen_o,
    output logic [2:0]        axi_awsize_o,
    output logic [1:0]        axi_awburst_o,
    output logic [1:0]        axi_awlock_o,
    output logic [3:0]        axi_awcache_o,
    output logic [2:0]        axi_awprot_o,
    output logic              axi_awvalid_o,
    input  logic              axi_awready_i,
    output logic [AXI_IW-1:0] axi_wid_o,
    output logic [AXI_DW-1:0] axi_wdata_o,
    output logic [3:0]        axi_wstrb_o,
    output logic              axi_wlast_o,
    output logic              axi_wvalid_o,
    input  logic              axi_wready_i,
    input  logic [AXI_IW-1:0] axi_bid_i,
    input  logic [1:0]        axi_bresp_i,
    input  logic              axi_bvalid_i,
    output logic              axi_bready_o,
    output logic [AXI_IW-1:0] axi_arid_o,
    output logic [AXI_AW-1:0] axi_araddr_o,
    output logic [3:0]        axi_arlen_o,
    output logic [2:0]        axi_arsize_o,
    output logic [1:0]        axi_arburst_o,
    output logic [1:0]        axi_arlock_o,
    output logic [3:0]        axi_arcache_o,
    output logic [2:0]        axi_arprot_o,
    output logic              axi_arvalid_o,
    input  logic              axi_arready_i,
    input  logic [AXI_IW-1:0] axi_rid_i,
    input  logic [AXI_DW-1:0] axi_rdata_i,
    input  logic [1:0]        axi_rresp_i,
    input  logic              axi_rlast_i,
    input  logic              axi_rvalid_i,
    output logic              axi_rready_o
);
`ifdef AXI_SYS_MASTER_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DRAIN} state_t;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
`else
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
`endif
    state_t            state_q, state_d;
    logic [AXI_AW-1:0] addr_q, addr_d;
    logic [AXI_DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]        strb_q, strb_d;
    logic              ack_q, ack_d, err_q, err_d;
    logic              addr_done_q, addr_done_d, w_done_q, w_done_d;
    logic              drain_w, drain_r, aw_hs, w_hs, ar_hs;

`ifdef AXI_SYS_MASTER_TIMEOUT_EN
    assign drain_w = state_q == DRAIN && wr_q;
    assign drain_r = state_q == DRAIN && !wr_q;
`else
    assign drain_w = 1'b0;
    assign drain_r = 1'b0;
`endif

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            addr_done_q <= 1'b0;
            w_done_q    <= 1'b0;
`ifdef AXI_SYS_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            wr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            addr_done_q <= addr_done_d;
            w_done_q    <= w_done_d;
`ifdef AXI_SYS_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
`endif
        end
    end

    // addr_done tracks the AW handshake for writes and the AR handshake for reads
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        addr_done_d = addr_done_q || aw_hs || ar_hs;
        w_done_d    = w_done_q || w_hs;
`ifdef AXI_SYS_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        wr_d        = wr_q;
`endif
        case (state_q)
            IDLE: if (!ack_q && (req_wen_i || req_ren_i)) begin
                addr_done_d = 1'b0;
                w_done_d    = 1'b0;
`ifdef AXI_SYS_MASTER_TIMEOUT_EN
                cnt_d       = CW'(1);
                wr_d        = req_wen_i;
`endif
                if (req_wen_i && req_ren_i) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end else if (req_wen_i) begin
                    state_d = WADDR;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    strb_d  = req_sel_i;
                end else begin
                    state_d = RADDR;
                    addr_d  = req_addr_i;
                end
            end
            WADDR: if (addr_done_d && w_done_d) state_d = WRESP;
            WRESP: if (axi_bvalid_i) begin
                state_d = IDLE;
                ack_d   = 1'b1;
                err_d   = axi_bresp_i[1] || axi_bid_i != AXI_IW'(AXI_ID);
            end
            RADDR: if (ar_hs) state_d = RDATA;
            RDATA: if (axi_rvalid_i) begin
                state_d = IDLE;
                ack_d   = 1'b1;
                rdata_d = axi_rdata_i;
                err_d   = axi_rresp_i[1] || axi_rid_i != AXI_IW'(AXI_ID) || !axi_rlast_i;
            end
`ifdef AXI_SYS_MASTER_TIMEOUT_EN
            DRAIN: if (wr_q ? axi_bvalid_i : axi_rvalid_i) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
`ifdef AXI_SYS_MASTER_TIMEOUT_EN
        if (state_q inside {WADDR, WRESP, RADDR, RDATA}) begin
            cnt_d = cnt_q + 1'b1;
            if (state_d != IDLE && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d = DRAIN;
                ack_d   = 1'b1;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        axi_awvalid_o = (state_q == WADDR || drain_w) && !addr_done_q;
        axi_wvalid_o  = (state_q == WADDR || drain_w) && !w_done_q;
        axi_arvalid_o = (state_q == RADDR || drain_r) && !addr_done_q;
        axi_bready_o  = state_q == WRESP || drain_w || drain_r;
        axi_rready_o  = state_q == RDATA || drain_w || drain_r;
    end

    assign aw_hs = axi_awvalid_o && axi_awready_i;
    assign w_hs  = axi_wvalid_o && axi_wready_i;
    assign ar_hs = axi_arvalid_o && axi_arready_i;

    assign req_rdata_o   = rdata_q;
    assign req_ack_o     = ack_q;
    assign req_err_o     = err_q;
    assign req_busy_o    = state_q != IDLE || ack_q;
    assign axi_awid_o    = AXI_IW'(AXI_ID);
    assign axi_wid_o     = AXI_IW'(AXI_ID);
    assign axi_arid_o    = AXI_IW'(AXI_ID);
    assign axi_awaddr_o  = addr_q;
    assign axi_araddr_o  = addr_q;
    assign axi_awlen_o   = 4'h0;
    assign axi_arlen_o   = 4'h0;
    assign axi_awsize_o  = 3'h2;
    assign axi_arsize_o  = 3'h2;
    assign axi_awburst_o = 2'b01;
    assign axi_arburst_o = 2'b01;
    assign axi_awlock_o  = 2'b00;
    assign axi_arlock_o  = 2'b00;
    assign axi_awcache_o = 4'h0;
    assign axi_arcache_o = 4'h0;
    assign axi_awprot_o  = 3'b010;
    assign axi_arprot_o  = 3'b010;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = strb_q;
    assign axi_wlast_o   = 1'b1;
endmodule

// File: tb/tb_axi_sys_master.sv
// tb_axi_sys_master: random and directed requests against a delay-configurable AXI slave,
// checked against a word-array model of the slave registers.
module tb_axi_sys_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_sel = '0;
    logic        req_wen = 1'b0, req_ren = 1'b0;
    logic [31:0] req_rdata;
    logic        req_ack, req_err, req_busy;
    logic [11:0] awid, wid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, awcache, arcache, wstrb;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;

    axi_sys_master #(.TIMEOUT_CYC(16)) dut (
        .axi_clk_i(clk), .axi_rst_i(rst),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
        .req_wen_i(req_wen), .req_ren_i(req_ren), .req_rdata_o(req_rdata),
        .req_ack_o(req_ack), .req_err_o(req_err), .req_busy_o(req_busy),
        .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
        .axi_awburst_o(awburst), .axi_awlock_o(awlock), .axi_awcache_o(awcache),
        .axi_awprot_o(awprot), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_wid_o(wid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
        .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
        .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache),
        .axi_arprot_o(arprot), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready)
    );

    always #5 clk = ~clk;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit force_err = 0, id_bad = 0, rlast_bad = 0, b_never = 0;
    logic [31:0] smem [4];

    int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, ack_n = 0, vcyc_n = 0;
    logic [31:0] cap_awaddr = '0, cap_araddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        cap_aw_ok = 0, cap_w_ok = 0, cap_ar_ok = 0;

    always @(posedge clk) begin
        if (awvalid && awready) begin
            aw_n <= aw_n + 1;
            cap_awaddr <= awaddr;
            cap_aw_ok <= awlen == 0 && awsize == 2 && awburst == 1 && awlock == 0 &&
                         awcache == 0 && awprot == 3'b010 && awid == 0;
        end
        if (wvalid && wready) begin
            w_n <= w_n + 1;
            cap_wdata <= wdata;
            cap_wstrb <= wstrb;
            cap_w_ok <= wlast && wid == 0;
        end
        if (arvalid && arready) begin
            ar_n <= ar_n + 1;
            cap_araddr <= araddr;
            cap_ar_ok <= arlen == 0 && arsize == 2 && arburst == 1 && arlock == 0 &&
                         arcache == 0 && arprot == 3'b010 && arid == 0;
        end
        if (bvalid && bready) b_n <= b_n + 1;
        if (rvalid && rready) r_n <= r_n + 1;
        if (req_ack) ack_n <= ack_n + 1;
        if (awvalid || wvalid || arvalid) vcyc_n <= vcyc_n + 1;
    end

    // slave: readies after a per-channel wait, one response per completed address+data
    initial begin
        int aw_w, w_w, ar_w, b_w, r_w, b_iss, r_iss;
        aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0; b_iss = 0; r_iss = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
        for (int i = 0; i < 4; i++) smem[i] = '0;
        forever begin
            @(negedge clk);
            awready = awvalid && aw_w >= aw_dly;
            aw_w = awvalid ? aw_w + 1 : 0;
            wready = wvalid && w_w >= w_dly;
            w_w = wvalid ? w_w + 1 : 0;
            arready = arvalid && ar_w >= ar_dly;
            ar_w = arvalid ? ar_w + 1 : 0;
            if (b_n == b_iss) begin
                bvalid = 0;
                if (aw_n > b_iss && w_n > b_iss && !b_never) begin
                    if (b_w >= b_dly) begin
                        bvalid = 1;
                        b_iss++;
                        b_w = 0;
                        bresp = (cap_awaddr < 16 && !force_err) ? 2'b00 : 2'b10;
                        bid = id_bad ? 12'h5 : 12'h0;
                        if (bresp == 2'b00)
                            for (int i = 0; i < 4; i++)
                                if (cap_wstrb[i]) smem[cap_awaddr[3:2]][i*8 +: 8] = cap_wdata[i*8 +: 8];
                    end else b_w++;
                end
            end
            if (r_n == r_iss) begin
                rvalid = 0;
                if (ar_n > r_iss) begin
                    if (r_w >= r_dly) begin
                        rvalid = 1;
                        r_iss++;
                        r_w = 0;
                        rresp = (cap_araddr < 16 && !force_err) ? 2'b00 : 2'b10;
                        rdata = cap_araddr < 16 ? smem[cap_araddr[3:2]] : 32'hDEADBEEF;
                        rid = id_bad ? 12'h5 : 12'h0;
                        rlast = !rlast_bad;
                    end else r_w++;
                end
            end
        end
    end

    int n_chk = 0, n_fail = 0;
    logic [31:0] ref_mem [4];
    logic [31:0] exp_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    task automatic run_req(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit pulse_busy, input bit probe_indep);
        int aw0, w0, ar0, ack0, v0, k;
        bit mapped, exp_err;
        aw0 = aw_n; w0 = w_n; ar0 = ar_n; ack0 = ack_n; v0 = vcyc_n;
        mapped = a < 16;
        if (we && re) exp_err = 1;
        else if (we) begin
            exp_err = !mapped || force_err || id_bad;
            if (mapped && !force_err) ref_mem[a[3:2]] = merge(ref_mem[a[3:2]], d, s);
        end else begin
            exp_err = !mapped || force_err || id_bad || rlast_bad;
            exp_rd = mapped ? ref_mem[a[3:2]] : 32'hDEADBEEF;
        end
        @(negedge clk);
        req_wen = we; req_ren = re; req_addr = a; req_wdata = d; req_sel = s;
        @(negedge clk);
        req_wen = 0; req_ren = 0;
        check("busy_after_accept", req_busy, 1);
        if (pulse_busy) begin
            req_wen = 1; req_addr = a ^ 32'h8; req_wdata = ~d;
            @(negedge clk);
            req_wen = 0;
        end
        if (probe_indep) begin
            @(negedge clk);
            check("wvalid_dropped", wvalid, 0);
            check("awvalid_held", awvalid, 1);
        end
        k = 0;
        while (!req_ack && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ack_seen", req_ack, 1);
        check("ack_err", req_err, exp_err);
        check("rdata", req_rdata, exp_rd);
        check("busy_at_ack", req_busy, 1);
        @(negedge clk);
        check("ack_single_pulse", req_ack, 0);
        check("busy_after_ack", req_busy, 0);
        check("aw_count", aw_n - aw0, we && !re);
        check("w_count", w_n - w0, we && !re);
        check("ar_count", ar_n - ar0, re && !we);
        if (we && !re) begin
            check("awaddr", cap_awaddr, a);
            check("wdata", cap_wdata, d);
            check("wstrb", cap_wstrb, s);
            check("aw_attr", {cap_aw_ok, cap_w_ok}, 2'b11);
        end
        if (re && !we) begin
            check("araddr", cap_araddr, a);
            check("ar_attr", cap_ar_ok, 1);
        end
        if (we && re) check("no_valid_cycles", vcyc_n - v0, 0);
        if (pulse_busy) begin
            repeat (3) @(negedge clk);
            check("one_ack_only", ack_n - ack0, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int ack0, k, op;
        logic [31:0] a, d;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", req_ack, 0);
        check("rst_err", req_err, 0);
        check("rst_busy", req_busy, 0);
        check("rst_rdata", req_rdata, 0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_regs", {awaddr ^ araddr, wdata, 28'h0, wstrb} | awaddr, 0);
        rst = 0;

        run_req(1, 0, 32'h0, 32'h66666666, 4'hF, 0, 0);
        run_req(0, 1, 32'h0, 32'h0, 4'h0, 0, 0);
        run_req(1, 0, 32'h4, 32'h12345678, 4'hF, 0, 0);
        ar_dly = 2; r_dly = 4;
        run_req(0, 1, 32'h4, 32'h0, 4'h0, 0, 0);
        ar_dly = 0; r_dly = 0; aw_dly = 3; w_dly = 0;
        run_req(1, 0, 32'h8, 32'hA5A5_0F0F, 4'b0101, 0, 1);
        aw_dly = 0;
        run_req(0, 1, 32'h8, 32'h0, 4'h0, 0, 0);
        run_req(0, 1, 32'h14, 32'h0, 4'h0, 0, 0);
        force_err = 1;
        run_req(1, 0, 32'hC, 32'hFFFF_FFFF, 4'hF, 0, 0);
        force_err = 0;
        run_req(1, 1, 32'h0, 32'h1, 4'hF, 0, 0);
        run_req(1, 0, 32'hC, 32'hCAFE_F00D, 4'hF, 1, 0);
        run_req(0, 1, 32'hC, 32'h0, 4'h0, 0, 0);

        // abort a write mid-flight with reset
        aw_dly = 10; w_dly = 10;
        ack0 = ack_n;
        @(negedge clk);
        req_wen = 1; req_addr = 32'h0; req_wdata = 32'h1111_2222; req_sel = 4'hF;
        @(negedge clk);
        req_wen = 0;
        @(negedge clk);
        check("midflight_awvalid", awvalid, 1);
        rst = 1;
        @(negedge clk);
        check("abort_valids", {awvalid, wvalid, arvalid}, 0);
        check("abort_busy", req_busy, 0);
        check("abort_rdata", req_rdata, 0);
        exp_rd = '0;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check("abort_no_ack", ack_n - ack0, 0);
        aw_dly = 0; w_dly = 0;

        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 5)) * 4;
            d = $urandom;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            force_err = $urandom_range(0, 7) == 0;
            id_bad = $urandom_range(0, 7) == 0;
            rlast_bad = $urandom_range(0, 7) == 0;
            if (op == 0) run_req(1, 1, a, d, 4'hF, 0, 0);
            else if (op < 5) run_req(1, 0, a, d, 4'($urandom_range(0, 15)), 0, 0);
            else run_req(0, 1, a, d, 4'h0, 0, 0);
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        force_err = 0; id_bad = 0; rlast_bad = 0;

`ifdef AXI_SYS_MASTER_TIMEOUT_EN
        b_never = 1;
        ack0 = ack_n;
        @(negedge clk);
        req_wen = 1; req_addr = 32'h0; req_wdata = 32'h7777_8888; req_sel = 4'hF;
        @(negedge clk);
        req_wen = 0;
        k = 0;
        while (!req_ack && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("timeout_ack", req_ack, 1);
        check("timeout_err", req_err, 1);
        check("timeout_busy", req_busy, 1);
        repeat (4) @(negedge clk);
        check("drain_busy", req_busy, 1);
        b_never = 0;
        ref_mem[0] = 32'h7777_8888;
        k = 0;
        while (req_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", req_busy, 0);
        check("drain_one_ack", ack_n - ack0, 1);
        run_req(0, 1, 32'h0, 32'h0, 4'h0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
